// File: rtl/mnist_ctrl_fsm.sv
// Sequencer for the 784-32-10 MNIST MLP accelerator.
// Walks load, L1 sweep, ReLU, L2 sweep and argmax; the datapath lives elsewhere.
module mnist_ctrl_fsm #(
    parameter int IMG_SIZE = 784,
    parameter int HID_SIZE = 32,
    parameter int PRE_CYC  = 2,
    parameter int RELU_CYC = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    output logic       o_done,
    output logic       o_busy,
    output logic [1:0] o_layer_sel,
    output logic [9:0] o_row_idx,
    output logic       o_mac_en_l1,
    output logic       o_mac_clr_l1,
    output logic       o_mac_en_l2,
    output logic       o_mac_clr_l2,
    output logic       o_load_img,
    output logic       o_comp_l1,
    output logic       o_apply_relu,
    output logic       o_comp_l2,
    output logic       o_find_max,
    output logic [9:0] o_cycle_cnt
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_L1_PRE,
        S_L1_RUN,
        S_RELU,
        S_L2_PRE,
        S_L2_RUN,
        S_MAX,
        S_DONE
    } state_t;

    localparam logic [9:0] L_PRE_LAST  = 10'(PRE_CYC - 1);
    localparam logic [9:0] L_IMG_LAST  = 10'(IMG_SIZE - 1);
    localparam logic [9:0] L_RELU_LAST = 10'(RELU_CYC - 1);
    localparam logic [9:0] L_HID_LAST  = 10'(HID_SIZE - 1);
    localparam logic [9:0] L_CNT_MAX   = 10'h3FF;

    state_t     r_state;
    state_t     w_next;
    logic [9:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            // Counter restarts on every transition and saturates rather than wrapping.
            if (w_next != r_state || r_state == S_IDLE) begin
                r_cnt <= '0;
            end else if (r_cnt != L_CNT_MAX) begin
                r_cnt <= r_cnt + 10'd1;
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        o_done       = 1'b0;
        o_busy       = 1'b0;
        o_layer_sel  = 2'd0;
        o_row_idx    = 10'd0;
        o_mac_en_l1  = 1'b0;
        o_mac_clr_l1 = 1'b0;
        o_mac_en_l2  = 1'b0;
        o_mac_clr_l2 = 1'b0;
        o_load_img   = 1'b0;
        o_comp_l1    = 1'b0;
        o_apply_relu = 1'b0;
        o_comp_l2    = 1'b0;
        o_find_max   = 1'b0;
        o_cycle_cnt  = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                o_cycle_cnt = 10'd0;
                if (i_start) w_next = S_LOAD;
            end
            S_LOAD: begin
                o_busy       = 1'b1;
                o_load_img   = 1'b1;
                o_mac_clr_l1 = 1'b1;
                o_mac_clr_l2 = 1'b1;
                w_next       = S_L1_PRE;
            end
            S_L1_PRE: begin
                o_busy    = 1'b1;
                o_comp_l1 = 1'b1;
                if (r_cnt == L_PRE_LAST) w_next = S_L1_RUN;
            end
            S_L1_RUN: begin
                o_busy      = 1'b1;
                o_comp_l1   = 1'b1;
                o_mac_en_l1 = 1'b1;
                o_row_idx   = r_cnt;
                if (r_cnt == L_IMG_LAST) w_next = S_RELU;
            end
            S_RELU: begin
                o_busy       = 1'b1;
                o_apply_relu = 1'b1;
                o_layer_sel  = 2'd1;
                if (r_cnt == L_RELU_LAST) w_next = S_L2_PRE;
            end
            S_L2_PRE: begin
                // Quiet cycle so the activation register captures as apply_relu falls.
                o_busy      = 1'b1;
                o_layer_sel = 2'd1;
                w_next      = S_L2_RUN;
            end
            S_L2_RUN: begin
                o_busy      = 1'b1;
                o_comp_l2   = 1'b1;
                o_mac_en_l2 = 1'b1;
                o_layer_sel = 2'd1;
                o_row_idx   = r_cnt;
                if (r_cnt == L_HID_LAST) w_next = S_MAX;
            end
            S_MAX: begin
                o_busy      = 1'b1;
                o_find_max  = 1'b1;
                o_layer_sel = 2'd2;
                w_next      = S_DONE;
            end
            S_DONE: begin
                o_done      = 1'b1;
                o_layer_sel = 2'd2;
                if (i_start) w_next = S_LOAD;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mnist_ctrl_fsm.sv
// Bench for mnist_ctrl_fsm: vector table, directed run sequences and
// random start/reset traffic checked against a timeline model.
module tb_mnist_ctrl_fsm;

    localparam int IMG  = 784;
    localparam int HID  = 32;
    localparam int PRE  = 2;
    localparam int RELU = 2;

    // Offsets of each phase measured in cycles from the LOAD cycle.
    localparam int T_L1P = 1;
    localparam int T_L1R = T_L1P + PRE;
    localparam int T_RL  = T_L1R + IMG;
    localparam int T_L2P = T_RL + RELU;
    localparam int T_L2R = T_L2P + 1;
    localparam int T_MX  = T_L2R + HID;
    localparam int T_DN  = T_MX + 1;

    typedef struct packed {
        logic       done;
        logic       busy;
        logic [1:0] ls;
        logic [9:0] row;
        logic       en1;
        logic       clr1;
        logic       en2;
        logic       clr2;
        logic       load;
        logic       c1;
        logic       relu;
        logic       c2;
        logic       fmax;
        logic [9:0] cnt;
    } outs_t;

    typedef struct {
        logic       rst;
        logic       start;
        logic       load;
        logic       c1;
        logic       en1;
        logic       busy;
        logic       done;
        logic [9:0] cnt;
    } vec_t;

    logic       clk;
    logic       i_rst;
    logic       i_start;
    logic       o_done;
    logic       o_busy;
    logic [1:0] o_layer_sel;
    logic [9:0] o_row_idx;
    logic       o_mac_en_l1;
    logic       o_mac_clr_l1;
    logic       o_mac_en_l2;
    logic       o_mac_clr_l2;
    logic       o_load_img;
    logic       o_comp_l1;
    logic       o_apply_relu;
    logic       o_comp_l2;
    logic       o_find_max;
    logic [9:0] o_cycle_cnt;

    int n_cmp;
    int n_bad;
    int t;

    mnist_ctrl_fsm dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .o_done       (o_done),
        .o_busy       (o_busy),
        .o_layer_sel  (o_layer_sel),
        .o_row_idx    (o_row_idx),
        .o_mac_en_l1  (o_mac_en_l1),
        .o_mac_clr_l1 (o_mac_clr_l1),
        .o_mac_en_l2  (o_mac_en_l2),
        .o_mac_clr_l2 (o_mac_clr_l2),
        .o_load_img   (o_load_img),
        .o_comp_l1    (o_comp_l1),
        .o_apply_relu (o_apply_relu),
        .o_comp_l2    (o_comp_l2),
        .o_find_max   (o_find_max),
        .o_cycle_cnt  (o_cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic outs_t model_outs(int tt);
        outs_t o;
        o = '0;
        if (tt < 0) return o;
        if (tt >= T_DN) begin
            o.done = 1'b1;
            o.ls   = 2'd2;
            o.cnt  = (tt - T_DN > 1023) ? 10'd1023 : 10'(tt - T_DN);
            return o;
        end
        o.busy = 1'b1;
        if (tt == 0) begin
            o.load = 1'b1;
            o.clr1 = 1'b1;
            o.clr2 = 1'b1;
        end else if (tt < T_L1R) begin
            o.c1  = 1'b1;
            o.cnt = 10'(tt - T_L1P);
        end else if (tt < T_RL) begin
            o.c1  = 1'b1;
            o.en1 = 1'b1;
            o.row = 10'(tt - T_L1R);
            o.cnt = 10'(tt - T_L1R);
        end else if (tt < T_L2P) begin
            o.relu = 1'b1;
            o.ls   = 2'd1;
            o.cnt  = 10'(tt - T_RL);
        end else if (tt < T_L2R) begin
            o.ls = 2'd1;
        end else if (tt < T_MX) begin
            o.c2  = 1'b1;
            o.en2 = 1'b1;
            o.ls  = 2'd1;
            o.row = 10'(tt - T_L2R);
            o.cnt = 10'(tt - T_L2R);
        end else begin
            o.fmax = 1'b1;
            o.ls   = 2'd2;
        end
        return o;
    endfunction

    function automatic outs_t dut_outs();
        outs_t a;
        a.done = o_done;
        a.busy = o_busy;
        a.ls   = o_layer_sel;
        a.row  = o_row_idx;
        a.en1  = o_mac_en_l1;
        a.clr1 = o_mac_clr_l1;
        a.en2  = o_mac_en_l2;
        a.clr2 = o_mac_clr_l2;
        a.load = o_load_img;
        a.c1   = o_comp_l1;
        a.relu = o_apply_relu;
        a.c2   = o_comp_l2;
        a.fmax = o_find_max;
        a.cnt  = o_cycle_cnt;
        return a;
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic step(input logic r, input logic s);
        outs_t e;
        outs_t a;
        i_rst   = r;
        i_start = s;
        @(posedge clk);
        if (r) t = -1;
        else if (t < 0 || t >= T_DN) t = s ? 0 : ((t < 0) ? -1 : t + 1);
        else t = t + 1;
        #1;
        e = model_outs(t);
        a = dut_outs();
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            if (n_bad <= 20)
                $display("FAIL model t=%0d actual=%h required=%h", t, a, e);
        end
    endtask

    // Launch at the first edge, optionally pulse start or reset mid-run.
    task automatic run_seq(input int p1, input int p2, input int rst_at, input string tag);
        int c1 = 0;
        int e1 = 0;
        int e2 = 0;
        int fm = 0;
        int got = 0;
        int bad_row = 0;
        int onehot_bad = 0;
        step(1'b0, 1'b1);
        check({tag, "_launch"}, {o_load_img, o_done, o_busy}, 3'b101);
        for (int n = 2; n <= 1000; n++) begin
            if (n == rst_at) begin
                step(1'b1, 1'b0);
                check({tag, "_rst_en1"}, o_mac_en_l1, 0);
                check({tag, "_rst_busy"}, o_busy, 0);
                return;
            end
            step(1'b0, (n == p1 || n == p2));
            if (o_comp_l1) c1++;
            if (o_mac_en_l1) begin
                if (o_row_idx != 10'(e1) || o_layer_sel != 2'd0) bad_row++;
                e1++;
            end
            if (o_mac_en_l2) begin
                if (o_row_idx != 10'(e2) || o_layer_sel != 2'd1) bad_row++;
                e2++;
            end
            if ($countones({o_load_img, o_comp_l1, o_apply_relu,
                            o_comp_l2, o_find_max, o_done}) > 1)
                onehot_bad++;
            if (o_find_max) fm = n;
            if (o_done) begin
                got = n;
                break;
            end
        end
        check({tag, "_done_at"}, got, 824);
        check({tag, "_comp_l1"}, c1, 786);
        check({tag, "_en_l1"}, e1, 784);
        check({tag, "_en_l2"}, e2, 32);
        check({tag, "_fmax_at"}, fm, 823);
        check({tag, "_rows"}, bad_row, 0);
        check({tag, "_onehot"}, onehot_bad, 0);
    endtask

    initial begin
        vec_t tbl[9];
        n_cmp   = 0;
        n_bad   = 0;
        t       = -1;
        i_rst   = 1'b1;
        i_start = 1'b0;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd1};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0};

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].rst, tbl[i].start);
            check($sformatf("vec%0d", i),
                  {o_load_img, o_comp_l1, o_mac_en_l1, o_busy, o_done, o_cycle_cnt},
                  {tbl[i].load, tbl[i].c1, tbl[i].en1, tbl[i].busy, tbl[i].done, tbl[i].cnt});
        end

        run_seq(0, 0, 0, "full");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        check("done_hold", {o_done, o_busy, o_cycle_cnt}, {2'b10, 10'd3});
        run_seq(0, 0, 0, "restart");
        step(1'b0, 1'b0);
        run_seq(101, 501, 0, "busy_ign");
        run_seq(0, 0, 401, "midrst");
        step(1'b0, 1'b0);
        check("idle_after_rst", {o_busy, o_done, o_cycle_cnt}, 12'd0);
        run_seq(0, 0, 0, "after_rst");

        for (int i = 0; i < 4000; i++) begin
            step(($urandom % 400) == 0, ($urandom % 40) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
